// File: rtl/io_pkg.sv
// Shared constants and types for the memory-mapped I/O port.
// Address decode selectors, register offsets and the byte type.
package io_pkg;

  localparam logic [1:0] IO_BASE_SEL = 2'b11;
  localparam logic [2:0] IO_UART_OFS = 3'd0;
  localparam logic [2:0] IO_CLK_OFS  = 3'd4;

  typedef logic [7:0] io_byte_t;

  // Little-endian byte select out of a 32-bit word.
  function automatic io_byte_t word_byte(input logic [31:0] word, input logic [1:0] idx);
    return word[{idx, 3'b000} +: 8];
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with occupancy count; DEPTH must be a power of two.
// A push is accepted when not full, or when full but popping in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   i_push,
  input  logic                   i_pop,
  input  logic [WIDTH-1:0]       i_data,
  output logic [WIDTH-1:0]       o_data,
  output logic [$clog2(DEPTH):0] o_count,
  output logic                   o_full,
  output logic                   o_empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_push;
  logic             w_pop;

  assign o_empty = (r_count == '0);
  assign o_full  = (r_count == FULL_CNT);
  assign o_count = r_count;
  assign o_data  = r_mem[r_rd_ptr];

  assign w_pop  = i_pop & ~o_empty;
  assign w_push = i_push & (~o_full | w_pop);

  // NOTE: state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // NOTE: storage has no reset; the pointers/count define which entries are valid.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_data;
  end

endmodule

// File: rtl/io_port_ctrl.sv
// Memory-mapped I/O port: UART TX FIFO, RX read path, stop/prog_done logic.
// Define IO_CYCLE_COUNTER_EN to include the 32-bit cycle counter and snapshot.
module io_port_ctrl
  import io_pkg::*;
#(
  parameter int TX_DEPTH    = 16,
  parameter int FULL_MARGIN = 2
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic [31:0] cpu_a,
  input  logic        cpu_wr,
  input  logic [7:0]  cpu_dout,
  output logic [7:0]  io_din,
  output logic        io_sel_q,
  output logic        io_buffer_full,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_pop,
  output logic        prog_done,
  output logic        tx_ovf
);

  localparam int CW = $clog2(TX_DEPTH) + 1;
  localparam logic [CW-1:0] FULL_THRESH = CW'(TX_DEPTH - FULL_MARGIN);

  logic          w_hit;
  logic          w_wr;
  logic          w_rd;
  logic [2:0]    w_ofs;
  logic          w_push_req;
  logic          w_stop_req;
  io_byte_t      w_push_data;
  logic          w_pop;
  logic          w_full;
  logic          w_empty;
  logic          w_drop;
  logic [CW-1:0] w_count;
  io_byte_t      w_fifo_data;
  io_byte_t      w_rd_data;
  logic [31:0]   w_cycle;
  logic [31:0]   w_snap;
  logic          w_unused;

  logic          r_stop_pend;
  logic          r_prog_done;
  logic          r_tx_ovf;
  logic          r_io_sel_q;
  io_byte_t      r_io_din;

  assign w_hit    = rdy_in & (cpu_a[17:16] == IO_BASE_SEL);
  assign w_ofs    = cpu_a[2:0];
  assign w_wr     = w_hit & cpu_wr;
  assign w_rd     = w_hit & ~cpu_wr;
  assign w_unused = ^{cpu_a[31:18], cpu_a[15:3]};

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    w_push_req  = 1'b0;
    w_stop_req  = 1'b0;
    w_push_data = '0;
    if (w_wr && !r_stop_pend) begin
      case (w_ofs)
        IO_UART_OFS: begin
          w_push_req  = (cpu_dout != 8'h00);
          w_push_data = cpu_dout;
        end
        IO_CLK_OFS: begin
          w_push_req = 1'b1;
          w_stop_req = 1'b1;
        end
        default: ;
      endcase
    end
  end

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (TX_DEPTH)
  ) u_tx_fifo (
    .clk     (clk_in),
    .rst_n   (rst_in),
    .i_push  (w_push_req),
    .i_pop   (w_pop),
    .i_data  (w_push_data),
    .o_data  (w_fifo_data),
    .o_count (w_count),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign w_pop  = ~w_empty & tx_ready;
  assign w_drop = w_push_req & w_full & ~w_pop;

`ifdef IO_CYCLE_COUNTER_EN
  logic [31:0] r_cycle;
  logic [31:0] r_snap;

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_cycle <= '0;
      r_snap  <= '0;
    end else begin
      r_cycle <= r_cycle + 32'd1;
      if (w_rd && (w_ofs == IO_CLK_OFS)) r_snap <= r_cycle;
    end
  end

  assign w_cycle = r_cycle;
  assign w_snap  = r_snap;
`else
  assign w_cycle = '0;
  assign w_snap  = '0;
`endif

  // Offset 4 returns the live low byte while the snapshot captures the rest.
  always_comb begin
    w_rd_data = '0;
    case (w_ofs)
      IO_UART_OFS: w_rd_data = rx_valid ? rx_data : 8'h00;
      IO_CLK_OFS:  w_rd_data = word_byte(w_cycle, 2'd0);
      3'd5:        w_rd_data = word_byte(w_snap, 2'd1);
      3'd6:        w_rd_data = word_byte(w_snap, 2'd2);
      3'd7:        w_rd_data = word_byte(w_snap, 2'd3);
      default:     w_rd_data = '0;
    endcase
  end

  // The stop marker is the only 0x00 that can ever enter the FIFO.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_io_din    <= '0;
      r_io_sel_q  <= 1'b0;
      r_stop_pend <= 1'b0;
      r_prog_done <= 1'b0;
      r_tx_ovf    <= 1'b0;
    end else begin
      r_io_sel_q <= w_rd;
      if (w_rd)       r_io_din    <= w_rd_data;
      if (w_stop_req) r_stop_pend <= 1'b1;
      if (w_drop)     r_tx_ovf    <= 1'b1;
      if (w_pop && r_stop_pend && (w_fifo_data == 8'h00)) r_prog_done <= 1'b1;
    end
  end

  assign io_din         = r_io_din;
  assign io_sel_q       = r_io_sel_q;
  assign io_buffer_full = (w_count >= FULL_THRESH);
  assign tx_data        = w_fifo_data;
  assign tx_valid       = ~w_empty;
  assign rx_pop         = w_rd & (w_ofs == IO_UART_OFS) & rx_valid;
  assign prog_done      = r_prog_done;
  assign tx_ovf         = r_tx_ovf;

endmodule
